// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor
//  Receive-side model of a 4-bit HD44780-style LCD bus. Registers E/RS/RW/DB once,
//  follows the 8-bit -> 4-bit init handshake, reassembles nibbles into bytes and
//  raises sticky flags for bus-timing and protocol violations.
// Ports
//  clk                  system clock, posedge
//  iReset               asynchronous active-high reset
//  iLCD_Data[3:0]       DB[7:4] nibble
//  iLCD_Enabled         E strobe
//  iLCD_RegisterSelect  RS (0 command, 1 data)
//  iLCD_ReadWrite       RW (must be 0)
//  oByte[7:0]           last reassembled byte
//  oByteRS              RS attached to oByte
//  oByteValid           1-cycle strobe for oByte/oByteRS
//  oMode4bit            bus is in 4-bit mode
//  oDataCount[7:0]      count of RS=1 bytes, wrapping
//  oErrPowerup/oErrWidth/oErrGap/oErrRead/oErrSeq  sticky violation flags
module lcd_bus_monitor #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned MIN_EN_CYCLES  = 12,
  parameter int unsigned MIN_GAP_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic [3:0] iLCD_Data,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  output logic [7:0] oByte,
  output logic       oByteRS,
  output logic       oByteValid,
  output logic       oMode4bit,
  output logic [7:0] oDataCount,
  output logic       oErrPowerup,
  output logic       oErrWidth,
  output logic       oErrGap,
  output logic       oErrRead,
  output logic       oErrSeq
);

  localparam int unsigned PW_W  = $clog2(POWERUP_CYCLES + 2);
  localparam int unsigned EN_W  = $clog2(MIN_EN_CYCLES + 2);
  localparam int unsigned GAP_W = $clog2(MIN_GAP_CYCLES + 2);

  localparam logic [PW_W-1:0]  PW_MAX  = PW_W'(POWERUP_CYCLES);
  localparam logic [EN_W-1:0]  EN_MAX  = EN_W'(MIN_EN_CYCLES);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP_CYCLES);

  typedef enum logic [1:0] {PWR_WAIT, SYNC8, HI4, LO4} state_t;

  state_t           r_state;
  logic             r_e;
  logic             r_e_d;
  logic [3:0]       r_d;
  logic             r_rs;
  logic             r_rw;
  logic [3:0]       r_cap_nib;
  logic             r_cap_rs;
  logic [3:0]       r_hi_nib;
  logic             r_hi_rs;
  logic             r_ignore;
  logic             r_had_fall;
  logic [PW_W-1:0]  r_pwr_cnt;
  logic [EN_W-1:0]  r_wid_cnt;
  logic [GAP_W-1:0] r_gap_cnt;

  logic w_rise;
  logic w_fall;

  // Edges are taken on the registered copy of E
  assign w_rise = r_e & ~r_e_d;
  assign w_fall = ~r_e & r_e_d;

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_state     <= PWR_WAIT;
      r_e         <= 1'b0;
      r_e_d       <= 1'b0;
      r_d         <= 4'h0;
      r_rs        <= 1'b0;
      r_rw        <= 1'b0;
      r_cap_nib   <= 4'h0;
      r_cap_rs    <= 1'b0;
      r_hi_nib    <= 4'h0;
      r_hi_rs     <= 1'b0;
      r_ignore    <= 1'b0;
      r_had_fall  <= 1'b0;
      r_pwr_cnt   <= '0;
      r_wid_cnt   <= '0;
      r_gap_cnt   <= '0;
      oByte       <= 8'h00;
      oByteRS     <= 1'b0;
      oByteValid  <= 1'b0;
      oMode4bit   <= 1'b0;
      oDataCount  <= 8'h00;
      oErrPowerup <= 1'b0;
      oErrWidth   <= 1'b0;
      oErrGap     <= 1'b0;
      oErrRead    <= 1'b0;
      oErrSeq     <= 1'b0;
    end else begin
      r_e        <= iLCD_Enabled;
      r_d        <= iLCD_Data;
      r_rs       <= iLCD_RegisterSelect;
      r_rw       <= iLCD_ReadWrite;
      r_e_d      <= r_e;
      oByteValid <= 1'b0;

      if (r_pwr_cnt < PW_MAX) r_pwr_cnt <= r_pwr_cnt + PW_W'(1);

      // Track the bus value of the most recent E-high cycle (falling-edge latch)
      if (r_e) begin
        r_cap_nib <= r_d;
        r_cap_rs  <= r_rs;
      end

      // E-high width, saturating at the threshold
      if (w_rise)                          r_wid_cnt <= EN_W'(1);
      else if (r_e && r_wid_cnt < EN_MAX)  r_wid_cnt <= r_wid_cnt + EN_W'(1);

      // E-low gap since the last fall, saturating at the threshold
      if (w_fall)                          r_gap_cnt <= GAP_W'(1);
      else if (!r_e && r_gap_cnt < GAP_MAX) r_gap_cnt <= r_gap_cnt + GAP_W'(1);

      if (w_rise) begin
        if (r_pwr_cnt < PW_MAX)                 oErrPowerup <= 1'b1;
        if (r_had_fall && r_gap_cnt < GAP_MAX)  oErrGap     <= 1'b1;
        r_ignore <= r_rw;
        if (r_rw)                        oErrRead <= 1'b1;
        else if (r_state == PWR_WAIT)    r_state  <= SYNC8;
      end

      if (w_fall) begin
        r_had_fall <= 1'b1;
        if (r_wid_cnt < EN_MAX) oErrWidth <= 1'b1;
      end

      // Nibble decode on the fall of an accepted pulse
      if (w_fall && !r_ignore) begin
        case (r_state)
          SYNC8: begin
            oByte      <= {r_cap_nib, 4'h0};
            oByteRS    <= r_cap_rs;
            oByteValid <= 1'b1;
            if (r_cap_rs) begin
              oErrSeq    <= 1'b1;
              oDataCount <= oDataCount + 8'd1;
            end
            if (r_cap_nib == 4'h2 && !r_cap_rs) begin
              r_state   <= HI4;
              oMode4bit <= 1'b1;
            end
          end
          HI4: begin
            r_hi_nib <= r_cap_nib;
            r_hi_rs  <= r_cap_rs;
            r_state  <= LO4;
          end
          LO4: begin
            oByte      <= {r_hi_nib, r_cap_nib};
            oByteRS    <= r_cap_rs;
            oByteValid <= 1'b1;
            if (r_cap_rs)            oDataCount <= oDataCount + 8'd1;
            if (r_cap_rs != r_hi_rs) oErrSeq    <= 1'b1;
            // Function set with DL=1 drops the bus back to 8-bit mode
            if (!r_cap_rs && r_hi_nib == 4'h3) begin
              r_state   <= SYNC8;
              oMode4bit <= 1'b0;
            end else begin
              r_state <= HI4;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// tb_lcd_bus_monitor
//  Scoreboard bench: the driver pushes expected bytes from a nibble-level reference
//  model; an independent monitor pops and compares on every oByteValid strobe.
module tb_lcd_bus_monitor;

  localparam int unsigned PWR  = 200;
  localparam int unsigned MEN  = 12;
  localparam int unsigned MGAP = 40;

  logic       clk = 1'b0;
  logic       iReset;
  logic [3:0] iLCD_Data;
  logic       iLCD_Enabled;
  logic       iLCD_RegisterSelect;
  logic       iLCD_ReadWrite;
  logic [7:0] oByte;
  logic       oByteRS;
  logic       oByteValid;
  logic       oMode4bit;
  logic [7:0] oDataCount;
  logic       oErrPowerup, oErrWidth, oErrGap, oErrRead, oErrSeq;

  always #5 clk = ~clk;

  lcd_bus_monitor #(
    .POWERUP_CYCLES(PWR),
    .MIN_EN_CYCLES (MEN),
    .MIN_GAP_CYCLES(MGAP)
  ) dut (
    .clk                (clk),
    .iReset             (iReset),
    .iLCD_Data          (iLCD_Data),
    .iLCD_Enabled       (iLCD_Enabled),
    .iLCD_RegisterSelect(iLCD_RegisterSelect),
    .iLCD_ReadWrite     (iLCD_ReadWrite),
    .oByte              (oByte),
    .oByteRS            (oByteRS),
    .oByteValid         (oByteValid),
    .oMode4bit          (oMode4bit),
    .oDataCount         (oDataCount),
    .oErrPowerup        (oErrPowerup),
    .oErrWidth          (oErrWidth),
    .oErrGap            (oErrGap),
    .oErrRead           (oErrRead),
    .oErrSeq            (oErrSeq)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    logic        rs;
    logic        m4;
    logic [7:0]  cnt;
    int unsigned at;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_m4, m_have_hi, m_hi_rs;
  logic [3:0]  m_hi;
  logic [7:0]  m_cnt;
  bit          e_pwr, e_wid, e_gap, e_read, e_seq;
  bit          had_fall;
  int unsigned rel_cyc, last_fall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-level meaning of one accepted nibble
  task automatic model_nib(input logic [3:0] n, input bit rs, input int unsigned at);
    exp_t e;
    bit   emit;
    emit = 1'b0;
    if (!m_m4) begin
      e.b = {n, 4'h0}; e.rs = rs; emit = 1'b1;
      if (rs) e_seq = 1'b1;
      if (n == 4'h2 && !rs) m_m4 = 1'b1;
    end else if (!m_have_hi) begin
      m_hi = n; m_hi_rs = rs; m_have_hi = 1'b1;
    end else begin
      e.b = {m_hi, n}; e.rs = rs; emit = 1'b1;
      if (rs != m_hi_rs) e_seq = 1'b1;
      m_have_hi = 1'b0;
      if (!rs && m_hi == 4'h3) m_m4 = 1'b0;
    end
    if (emit) begin
      if (rs) m_cnt = m_cnt + 8'd1;
      e.m4 = m_m4; e.cnt = m_cnt; e.at = at;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One E pulse of 'hi' cycles, followed by 'gap' cycles of E low
  task automatic send_nib(input logic [3:0] n, input bit rs, input bit rw,
                          input int hi, input int gap);
    int unsigned r, c;
    @(posedge clk); #1;
    r = cyc;
    if (r - rel_cyc < PWR) e_pwr = 1'b1;
    if (had_fall && (r - last_fall) < MGAP) e_gap = 1'b1;
    if (rw) e_read = 1'b1;
    if (hi < int'(MEN)) e_wid = 1'b1;
    iLCD_Data = n; iLCD_RegisterSelect = rs; iLCD_ReadWrite = rw; iLCD_Enabled = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    iLCD_Enabled = 1'b0;
    iLCD_ReadWrite = 1'b0;
    // Bus garbage after the fall must not reach the captured nibble
    iLCD_Data = 4'($urandom);
    iLCD_RegisterSelect = 1'($urandom);
    c = cyc;
    had_fall = 1'b1;
    last_fall = c;
    if (!rw) model_nib(n, rs, c + 2);
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rs);
    send_nib(b[7:4], rs, 1'b0, 13, 45);
    send_nib(b[3:0], rs, 1'b0, 13, 45);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d strobes outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_state(input string name);
    @(negedge clk);
    chk({name, "_flags"}, 32'({oErrPowerup, oErrWidth, oErrGap, oErrRead, oErrSeq}),
        32'({e_pwr, e_wid, e_gap, e_read, e_seq}));
    chk({name, "_mode4"}, 32'(oMode4bit), 32'(m_m4));
    chk({name, "_count"}, 32'(oDataCount), 32'(m_cnt));
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1;
    iReset = 1'b1;
    iLCD_Enabled = 1'b0;
    iLCD_ReadWrite = 1'b0;
    @(negedge clk);
    chk({name, "_rst_outs"},
        32'({oByte, oByteRS, oByteValid, oMode4bit, oDataCount,
             oErrPowerup, oErrWidth, oErrGap, oErrRead, oErrSeq}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    iReset = 1'b0;
    rel_cyc = cyc;
    m_m4 = 1'b0; m_have_hi = 1'b0; m_hi = 4'h0; m_hi_rs = 1'b0; m_cnt = 8'h00;
    e_pwr = 1'b0; e_wid = 1'b0; e_gap = 1'b0; e_read = 1'b0; e_seq = 1'b0;
    had_fall = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the scoreboard, on the expected cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (oByteValid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got byte %0h rs %0b, expected no strobe", oByte, oByteRS);
        end else begin
          e = q.pop_front();
          chk("strobe_byte",  32'(oByte),      32'(e.b));
          chk("strobe_rs",    32'(oByteRS),    32'(e.rs));
          chk("strobe_mode4", 32'(oMode4bit),  32'(e.m4));
          chk("strobe_count", 32'(oDataCount), 32'(e.cnt));
          chk("strobe_cycle", cyc,             e.at);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] init_seq [12];
    logic [3:0] nb;
    bit         rs;
    init_seq = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    iReset = 1'b1; iLCD_Data = 4'h0; iLCD_Enabled = 1'b0;
    iLCD_RegisterSelect = 1'b0; iLCD_ReadWrite = 1'b0;
    rel_cyc = 0; last_fall = 0;

    // T1: full init sequence
    do_reset("T1");
    idle(PWR + 20);
    foreach (init_seq[i]) send_nib(init_seq[i], 1'b0, 1'b0, 13, 50);
    drain("T1");
    check_state("T1");

    // T2: two data bytes
    send_byte(8'h41, 1'b1);
    send_byte(8'h6F, 1'b1);
    drain("T2");
    check_state("T2");

    // T4: read pulse ignored, RS mismatch, return to 8-bit
    send_nib(4'h5, 1'b0, 1'b1, 13, 45);
    send_nib(4'h4, 1'b1, 1'b0, 13, 45);
    send_nib(4'h1, 1'b0, 1'b0, 13, 45);
    send_byte(8'h38, 1'b0);
    drain("T4");
    check_state("T4");

    // Random nibble stream against the model
    send_nib(4'h2, 1'b0, 1'b0, 13, 45);
    for (int i = 0; i < 150; i++) begin
      nb = 4'($urandom);
      rs = ($urandom_range(0, 3) == 0);
      send_nib(nb, rs, 1'b0, int'($urandom_range(MEN, MEN + 3)),
               int'($urandom_range(MGAP, MGAP + 5)));
    end
    drain("RND");
    check_state("RND");

    // T6: 256 data bytes wrap the counter
    do_reset("T6");
    idle(PWR + 20);
    send_nib(4'h2, 1'b0, 1'b0, 13, 45);
    for (int i = 0; i < 256; i++)
      send_byte(8'($urandom), 1'b1);
    drain("T6");
    check_state("T6");
    chk("T6_wrap", 32'(oDataCount), 32'd0);

    // T5: reset in the middle of a byte
    do_reset("T5a");
    idle(PWR + 20);
    send_nib(4'h2, 1'b0, 1'b0, 13, 45);
    send_nib(4'h4, 1'b0, 1'b0, 13, 45);
    drain("T5a");
    do_reset("T5b");
    idle(PWR + 20);
    send_nib(4'h3, 1'b0, 1'b0, 13, 45);
    drain("T5");
    check_state("T5");

    // T3: power-up, width and gap violations
    do_reset("T3");
    idle(20);
    send_nib(4'h3, 1'b0, 1'b0, 13, 10);
    send_nib(4'h3, 1'b0, 1'b0, 5, 45);
    drain("T3");
    check_state("T3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
